ws2812_chain_driver: RTL and testbench

Parametrised WS2812B serial driver that streams a frame of NUM_LEDS 24-bit GRB pixels from an external pixel store onto a single data line, then holds the line low for the latch (reset) interval. It replaces the single-colour fixed driver in the LED front end. Bit-cell timing derives from CLK_HZ, pixels are fetched by address with one-cycle read latency, and a global 8-bit brightness scale applies per frame.

---
 rtl/ws2812_pkg.sv | 14 +
 rtl/ws2812_bit_cell.sv | 32 +++
 rtl/ws2812_chain_driver.sv | 135 +++++++++++++
 tb/tb_ws2812_chain_driver.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/ws2812_pkg.sv
// rtl/ws2812_pkg.sv - shared state encoding, timing helper and GRB field offsets
package ws2812_pkg;

  typedef enum logic [1:0] {IDLE, FETCH, SEND, LATCH} state_t;

  localparam int G_LSB = 16;
  localparam int R_LSB = 8;
  localparam int B_LSB = 0;

  function automatic int cycles_from_ns(input longint clk_hz, input longint ns);
    return int'((clk_hz / longint'(1_000_000)) * ns / longint'(1000));
  endfunction

endpackage

// File: rtl/ws2812_bit_cell.sv
// rtl/ws2812_bit_cell.sv - one WS2812 bit period: high phase by bit value, cell_end on last cycle
module ws2812_bit_cell #(
  parameter int T0H     = 20,
  parameter int T1H     = 40,
  parameter int BIT_LEN = 62,
  localparam int CW     = $clog2(BIT_LEN)
) (
  input  logic clk,
  input  logic resetn,
  input  logic load,
  input  logic run,
  input  logic bit_val,
  output logic high,
  output logic cell_end
);

  logic [CW-1:0] cnt;

  assign cell_end = run && (cnt == CW'(BIT_LEN - 1));
  assign high     = run && (cnt < (bit_val ? CW'(T1H) : CW'(T0H)));

  always_ff @(posedge clk) begin
    if (!resetn) begin
      cnt <= '0;
    end else if (load || cell_end) begin
      cnt <= '0;
    end else if (run) begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/ws2812_chain_driver.sv
// rtl/ws2812_chain_driver.sv - streams NUM_LEDS brightness-scaled GRB pixels onto a WS2812B line
module ws2812_chain_driver
  import ws2812_pkg::*;
#(
  parameter int CLK_HZ   = 50_000_000,
  parameter int NUM_LEDS = 8,
  parameter int T0H_NS   = 400,
  parameter int T1H_NS   = 800,
  parameter int BIT_NS   = 1250,
  parameter int LATCH_US = 300,
  localparam int ADDR_W  = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1
) (
  input  logic              CLOCK_50,
  input  logic              KEY0,
  input  logic              start,
  input  logic [7:0]        bright,
  output logic [ADDR_W-1:0] pix_addr,
  input  logic [23:0]       pix_grb,
  output logic              busy,
  output logic              done,
  output logic              out
);

  localparam int T0H_C   = cycles_from_ns(longint'(CLK_HZ), longint'(T0H_NS));
  localparam int T1H_C   = cycles_from_ns(longint'(CLK_HZ), longint'(T1H_NS));
  localparam int BIT_C   = cycles_from_ns(longint'(CLK_HZ), longint'(BIT_NS));
  localparam int LATCH_C = cycles_from_ns(longint'(CLK_HZ), longint'(LATCH_US) * 1000);
  localparam int LW      = $clog2(LATCH_C + 1);

  if (!(T0H_C < T1H_C && T1H_C < BIT_C)) begin : g_bad_timing
    $error("ws2812_chain_driver: need T0H < T1H < BIT in clock cycles");
  end

  function automatic logic [7:0] scale8(input logic [7:0] c, input logic [7:0] b);
    return 8'(({9'd0, c} * ({9'd0, b} + 17'd1)) >> 8);
  endfunction

  function automatic logic [23:0] scale_grb(input logic [23:0] px, input logic [7:0] b);
    return {scale8(px[G_LSB +: 8], b), scale8(px[R_LSB +: 8], b), scale8(px[B_LSB +: 8], b)};
  endfunction

  state_t            state, state_nx;
  logic [23:0]       shift_q;
  logic [4:0]        bit_cnt;
  logic [ADDR_W-1:0] pix_cnt;
  logic [ADDR_W-1:0] addr_nx;
  logic [7:0]        bright_q;
  logic [LW-1:0]     latch_cnt;
  logic              cell_high, cell_end, last_bit, last_pix, latch_end, load_cell;

  assign last_bit  = cell_end && (bit_cnt == 5'd0);
  assign last_pix  = (pix_cnt == ADDR_W'(NUM_LEDS - 1));
  // one extra LATCH cycle absorbs the registered-output offset on out
  assign latch_end = (latch_cnt == LW'(LATCH_C));
  assign addr_nx   = (pix_addr == ADDR_W'(NUM_LEDS - 1)) ? '0 : pix_addr + ADDR_W'(1);
  assign busy      = (state != IDLE);

  ws2812_bit_cell #(
    .T0H    (T0H_C),
    .T1H    (T1H_C),
    .BIT_LEN(BIT_C)
  ) u_bit_cell (
    .clk     (CLOCK_50),
    .resetn  (KEY0),
    .load    (load_cell),
    .run     (state == SEND),
    .bit_val (shift_q[23]),
    .high    (cell_high),
    .cell_end(cell_end)
  );

  always_ff @(posedge CLOCK_50) begin
    if (!KEY0) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    load_cell = 1'b0;
    case (state)
      IDLE:    if (start) state_nx = FETCH;
      FETCH:   begin state_nx = SEND; load_cell = 1'b1; end
      SEND:    if (last_bit && last_pix) state_nx = LATCH;
      LATCH:   if (latch_end) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (!KEY0) begin
      pix_addr  <= '0;
      pix_cnt   <= '0;
      bit_cnt   <= '0;
      shift_q   <= '0;
      bright_q  <= '0;
      latch_cnt <= '0;
      done      <= 1'b0;
      out       <= 1'b0;
    end else begin
      done <= 1'b0;
      out  <= cell_high;
      case (state)
        IDLE: if (start) begin
          bright_q <= bright;
          pix_addr <= '0;
          pix_cnt  <= '0;
        end
        FETCH: begin
          shift_q  <= scale_grb(pix_grb, bright_q);
          bit_cnt  <= 5'd23;
          pix_addr <= addr_nx;
        end
        SEND: begin
          latch_cnt <= '0;
          // next pixel loads on the final cycle of bit 0 so cells stay contiguous
          if (cell_end && bit_cnt != 5'd0) begin
            shift_q <= shift_q << 1;
            bit_cnt <= bit_cnt - 5'd1;
          end else if (last_bit && !last_pix) begin
            shift_q  <= scale_grb(pix_grb, bright_q);
            bit_cnt  <= 5'd23;
            pix_addr <= addr_nx;
            pix_cnt  <= pix_cnt + ADDR_W'(1);
          end
        end
        LATCH: begin
          latch_cnt <= latch_cnt + LW'(1);
          if (latch_end) done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ws2812_chain_driver.sv
// tb/tb_ws2812_chain_driver.sv - randomized frame checks against a waveform-level reference model
module tb_ws2812_chain_driver;

  logic clk = 1'b0;
  always #10 clk = ~clk;

  logic        key0, start, sel_b;
  logic [7:0]  bright;
  logic [23:0] store [3];
  logic [1:0]  addr_a;
  logic        addr_b;
  logic [23:0] grb_a, grb_b;
  logic        busy_a, done_a, out_a, busy_b, done_b, out_b;
  logic        out_s, busy_s, done_s;
  logic [1:0]  addr_s;
  logic        start_a, start_b;

  int n_chk = 0;
  int n_pass = 0;

  assign start_a = start & ~sel_b;
  assign start_b = start & sel_b;
  assign out_s   = sel_b ? out_b  : out_a;
  assign busy_s  = sel_b ? busy_b : busy_a;
  assign done_s  = sel_b ? done_b : done_a;
  assign addr_s  = sel_b ? {1'b0, addr_b} : addr_a;

  always @(posedge clk) begin
    grb_a <= store[addr_a];
    grb_b <= store[addr_b];
  end

  ws2812_chain_driver #(.NUM_LEDS(3), .LATCH_US(2)) dut_a (
    .CLOCK_50(clk), .KEY0(key0), .start(start_a), .bright(bright), .pix_addr(addr_a),
    .pix_grb(grb_a), .busy(busy_a), .done(done_a), .out(out_a)
  );

  ws2812_chain_driver #(.CLK_HZ(100_000_000), .NUM_LEDS(1)) dut_b (
    .CLOCK_50(clk), .KEY0(key0), .start(start_b), .bright(bright), .pix_addr(addr_b),
    .pix_grb(grb_b), .busy(busy_b), .done(done_b), .out(out_b)
  );

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [23:0] model_scale(input logic [23:0] px, input int br);
    int g, r, b;
    g = (int'(px[23:16]) * (br + 1)) / 256;
    r = (int'(px[15:8])  * (br + 1)) / 256;
    b = (int'(px[7:0])   * (br + 1)) / 256;
    return {8'(g), 8'(r), 8'(b)};
  endfunction

  // mode 0: plain frame, 1: extra start pulses while busy, 2: reset at bit 10 of pixel 1
  task automatic run_frame(input int mode, input int n, input int t0h, input int t1h,
                           input int bitc, input int latc);
    bit          ew[$];
    bit          got[$];
    logic [1:0]  aseq[$];
    logic [23:0] exp_px [3];
    logic [23:0] dec;
    int f, t, done_t, rise_t, busy_bad, wave_err, ones, idx, bound, rst_t;
    f = n * 24 * bitc;
    for (int p = 0; p < n; p++) begin
      exp_px[p] = model_scale(store[p], int'(bright));
      for (int b = 23; b >= 0; b--)
        for (int c = 0; c < bitc; c++) ew.push_back(c < (exp_px[p][b] ? t1h : t0h));
    end
    for (int c = 0; c < latc; c++) ew.push_back(1'b0);

    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    chk("accept_busy", int'(busy_s), 1);
    chk("accept_addr", int'(addr_s), 0);

    done_t = -1; rise_t = -1; busy_bad = 0;
    rst_t = 2 + (24 + 10) * bitc + 5;
    bound = 2 + f + latc + 20;
    aseq.push_back(addr_s);
    for (t = 0; t < bound && done_t < 0; t++) begin
      if (t > 0) @(negedge clk);
      got.push_back(out_s);
      if (rise_t < 0 && out_s) rise_t = t;
      if (done_s) done_t = t;
      else if (!busy_s) busy_bad++;
      if (addr_s != aseq[$]) aseq.push_back(addr_s);
      start = (mode == 1) && (t == 700 || t == 2 + f + latc / 2);
      if (mode == 2 && t == rst_t) begin
        key0 = 1'b0;
        @(negedge clk);
        key0 = 1'b1;
        chk("rst_out", int'(out_s), 0);
        chk("rst_busy", int'(busy_s), 0);
        chk("rst_addr", int'(addr_s), 0);
        return;
      end
    end
    start = 1'b0;

    chk("done_seen", int'(done_t >= 0), 1);
    chk("busy_at_done", int'(busy_s), 0);
    chk("first_rise", rise_t, 2);
    if (rise_t < 0) rise_t = 0;
    chk("frame_len", done_t - rise_t, f + latc);
    chk("busy_held", busy_bad, 0);

    wave_err = 0;
    for (int j = 0; j < f + latc; j++) begin
      idx = rise_t + j;
      if (idx >= got.size()) wave_err++;
      else if (got[idx] != ew[j]) wave_err++;
    end
    chk("wave", wave_err, 0);

    for (int p = 0; p < n; p++) begin
      dec = '0;
      for (int b = 23; b >= 0; b--) begin
        ones = 0;
        for (int c = 0; c < bitc; c++) begin
          idx = rise_t + (p * 24 + 23 - b) * bitc + c;
          if (idx < got.size() && got[idx]) ones++;
        end
        dec[b] = (ones > (t0h + t1h) / 2);
      end
      chk($sformatf("pixel%0d", p), int'(dec), int'(exp_px[p]));
    end

    if (n == 3)
      chk("addr_seq", (aseq.size() == 4) ? int'({aseq[0], aseq[1], aseq[2], aseq[3]}) : 255,
          int'(8'b00_01_10_00));

    busy_bad = 0;
    for (int j = 0; j < 150; j++) begin
      @(negedge clk);
      if (busy_s || done_s) busy_bad++;
    end
    chk("idle_after", busy_bad, 0);
  endtask

  initial begin
    key0 = 1'b0; start = 1'b0; bright = 8'd0; sel_b = 1'b0;
    store = '{24'h0, 24'h0, 24'h0};
    repeat (3) @(negedge clk);
    chk("reset_out_a",  int'(out_a),  0);
    chk("reset_busy_a", int'(busy_a), 0);
    chk("reset_done_a", int'(done_a), 0);
    chk("reset_addr_a", int'(addr_a), 0);
    chk("reset_out_b",  int'(out_b),  0);
    chk("reset_busy_b", int'(busy_b), 0);
    key0 = 1'b1;
    @(negedge clk);

    store = '{24'h000001, 24'h800000, 24'hAAAAAA};
    bright = 8'd255;
    run_frame(0, 3, 20, 40, 62, 100);

    store = '{24'($urandom), 24'($urandom), 24'($urandom)};
    bright = 8'd0;
    run_frame(0, 3, 20, 40, 62, 100);

    store = '{24'hFF80FF, 24'($urandom), 24'($urandom)};
    bright = 8'd127;
    run_frame(1, 3, 20, 40, 62, 100);

    store = '{24'($urandom), 24'($urandom), 24'($urandom)};
    bright = 8'($urandom);
    run_frame(2, 3, 20, 40, 62, 100);
    run_frame(0, 3, 20, 40, 62, 100);

    store = '{24'($urandom), 24'($urandom), 24'($urandom)};
    bright = 8'($urandom);
    run_frame(0, 3, 20, 40, 62, 100);

    sel_b = 1'b1;
    store = '{24'hFF0000, 24'h0, 24'h0};
    bright = 8'd255;
    run_frame(0, 1, 40, 80, 125, 30000);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
